// File: rtl/tap_frequency_meter.sv
// Gated edge counter for a divided tap: resynchronises io_in[2], counts rising edges
// over a 2^(GATE_BASE_LOG2+2*gsel) clock window and shows the latched count on io_out.
module tap_frequency_meter #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 16,
  parameter int GATE_BASE_LOG2 = 6
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int TMR_W = GATE_BASE_LOG2 + 6;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  logic       clk;
  logic       rst_n;
  logic       sig;
  logic       hold;
  logic [1:0] gsel;
  logic [1:0] dsel;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign sig   = io_in[2];
  assign gsel  = io_in[4:3];
  assign hold  = io_in[5];
  assign dsel  = io_in[7:6];

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic               sync_q;
  logic               prev_q;
  logic               rise;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   gate_last;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               ovf_run_q, ovf_run_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic [1:0]         gsel_q, gsel_d;
  logic               count_sat;
  logic [CNT_W+7:0]   result_ext;

  assign sync_q    = sync_ff[SYNC_STAGES-1];
  assign rise      = sync_q & ~prev_q;
  assign count_sat = (count_q == {CNT_W{1'b1}});

  // For gsel_q==3 the shift reaches TMR_W, wrapping to zero so W-1 becomes all ones.
  always_comb begin
    gate_last = (TMR_W'(1) << (GATE_BASE_LOG2 + 2 * int'(gsel_q))) - TMR_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    ovf_run_d = ovf_run_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    gsel_d    = gsel_q;
    case (state_q)
      IDLE: begin
        state_d   = COUNT;
        gsel_d    = gsel;
        timer_d   = '0;
        count_d   = '0;
        ovf_run_d = 1'b0;
      end
      COUNT: begin
        timer_d = timer_q + TMR_W'(1);
        if (rise) begin
          if (count_sat) ovf_run_d = 1'b1;
          else           count_d   = count_q + CNT_W'(1);
        end
        // A rise in the closing cycle is folded into the latched result.
        if (timer_q == gate_last) begin
          if (!hold) begin
            result_d = count_sat ? count_q : count_q + CNT_W'(rise);
            ovf_d    = ovf_run_q | (count_sat & rise);
            valid_d  = 1'b1;
          end
          count_d   = '0;
          ovf_run_d = 1'b0;
          timer_d   = '0;
          gsel_d    = gsel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_ff   <= '0;
      prev_q    <= 1'b0;
      timer_q   <= '0;
      count_q   <= '0;
      ovf_run_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      gsel_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], sig};
      prev_q    <= sync_q;
      timer_q   <= timer_d;
      count_q   <= count_d;
      ovf_run_q <= ovf_run_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      gsel_q    <= gsel_d;
    end
  end

  // Zero-extension makes the upper byte read 0x00 when CNT_W is 8.
  assign result_ext = {8'h00, result_q};

  always_comb begin
    io_out = 8'h00;
    case (dsel)
      2'b00: io_out = result_q[7:0];
      2'b01: io_out = result_ext[15:8];
      2'b10: io_out = {valid_q, ovf_q, gsel_q, hold, sync_q, (state_q == COUNT), 1'b0};
      2'b11: io_out = count_q[7:0];
      default: io_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tap_frequency_meter.sv
// Bench for tap_frequency_meter: one stimulus stream drives a CNT_W=16 and a CNT_W=8
// instance; a window-level edge-counting model predicts every display byte.
module tb_tap_frequency_meter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] gsel = 2'b00;
  logic [1:0] dsel = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out16;
  logic [7:0] io_out8;

  assign io_in = {dsel, hold, gsel, sig, rst_n, clk};

  tap_frequency_meter #(.SYNC_STAGES(S), .CNT_W(16), .GATE_BASE_LOG2(6)) dut16 (
    .io_in (io_in),
    .io_out(io_out16)
  );

  tap_frequency_meter #(.SYNC_STAGES(S), .CNT_W(8), .GATE_BASE_LOG2(6)) dut8 (
    .io_in (io_in),
    .io_out(io_out8)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sampled tap history, raw rise total per gate window.
  logic exp_q[$];
  int   m_running = 0;
  int   m_gq = 0;
  int   m_pos = 0;
  int   m_sum = 0;
  int   m_res = 0;
  int   m_valid = 0;
  int   m_windows = 0;

  function automatic int win_len(input int g);
    return 1 << (6 + 2 * g);
  endfunction

  task automatic model_edge();
    int   n;
    logic r;
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i <= S; i++) exp_q.push_back(1'b0);
      m_running = 0; m_gq = 0; m_pos = 0; m_sum = 0; m_res = 0; m_valid = 0;
      return;
    end
    n = exp_q.size();
    r = exp_q[n-S] & ~exp_q[n-S-1];
    exp_q.push_back(sig);
    if (exp_q.size() > 8) void'(exp_q.pop_front());
    if (m_running == 0) begin
      m_running = 1; m_gq = int'(gsel); m_pos = 0; m_sum = 0;
    end else begin
      m_sum += int'(r);
      m_pos++;
      if (m_pos == win_len(m_gq)) begin
        if (!hold) begin
          m_res = m_sum;
          m_valid = 1;
        end
        m_windows++;
        m_sum = 0; m_pos = 0; m_gq = int'(gsel);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  function automatic logic [7:0] exp_byte(input int w, input logic [1:0] d);
    int   cap;
    int   r;
    int   c;
    logic o;
    logic sq;
    cap = (1 << w) - 1;
    r   = (m_res > cap) ? cap : m_res;
    o   = (m_res > cap);
    c   = (m_sum > cap) ? cap : m_sum;
    sq  = exp_q[exp_q.size() - S];
    case (d)
      2'b00: return 8'(r);
      2'b01: return 8'(r >> 8);
      2'b10: return {m_valid[0], o, 2'(m_gq), hold, sq, m_running[0], 1'b0};
      default: return 8'(c);
    endcase
  endfunction

  // Stimulus source: 0 = constant level, 1 = square wave, 2 = random noise.
  int   sig_mode = 0;
  int   sig_period = 4;
  logic sig_level = 1'b0;
  int   ph = 0;

  task automatic step();
    @(negedge clk);
    dsel = 2'($urandom_range(0, 3));
    case (sig_mode)
      0: sig = sig_level;
      1: begin
        sig = ((ph % sig_period) < (sig_period / 2));
        ph++;
      end
      default: sig = 1'($urandom);
    endcase
    #1;
    check("disp16", {8'h00, io_out16}, {8'h00, exp_byte(16, dsel)});
    check("disp8",  {8'h00, io_out8},  {8'h00, exp_byte(8, dsel)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_windows(input int n);
    int target;
    int budget;
    target = m_windows + n;
    budget = 0;
    while (m_windows < target && budget < 20000) begin
      step();
      budget++;
    end
    if (m_windows < target) check("win_timeout", 16'd0, 16'd1);
  endtask

  task automatic peek(input logic [1:0] d, output logic [7:0] v16, output logic [7:0] v8);
    dsel = d;
    #1;
    v16 = io_out16;
    v8  = io_out8;
  endtask

  logic [7:0] a16, a8, b16, b8;

  initial begin
    for (int i = 0; i <= S; i++) exp_q.push_back(1'b0);

    // Reset with the tap toggling.
    rst_n = 1'b0; sig_mode = 2;
    run(3);
    peek(2'b00, a16, a8); check("rst_res_lo", {a16, a8}, 16'h0000);
    peek(2'b01, a16, a8); check("rst_res_hi", {a16, a8}, 16'h0000);
    peek(2'b11, a16, a8); check("rst_count",  {a16, a8}, 16'h0000);
    peek(2'b10, a16, a8); check("rst_status", {a16 & 8'hFB, a8 & 8'hFB}, 16'h0000);

    // W=64, period 4.
    gsel = 2'd0; sig_mode = 1; sig_period = 4; ph = 0;
    @(negedge clk); rst_n = 1'b1;
    wait_windows(3);
    peek(2'b00, a16, a8); check("p4_res", {8'h00, a16}, 16'd16);
    peek(2'b01, a16, a8); check("p4_hi", {8'h00, a16}, 16'd0);
    peek(2'b10, a16, a8); check("p4_valid_ovf", {14'd0, a16[7:6]}, 16'b10);

    // W=256, period 10.
    gsel = 2'd1; sig_period = 10;
    wait_windows(3);
    peek(2'b00, a16, a8); check("p10_range", 16'((a16 == 8'd25) || (a16 == 8'd26)), 16'd1);
    peek(2'b01, a16, a8); check("p10_hi", {8'h00, a16}, 16'd0);

    // W=1024, period 2 saturates the 8-bit instance.
    gsel = 2'd2; sig_period = 2;
    wait_windows(2);
    peek(2'b00, a16, a8); peek(2'b10, b16, b8);
    check("sat8_res", {8'h00, a8}, 16'h00FF);
    check("sat8_ovf", {15'd0, b8[6]}, 16'd1);
    check("sat16_res", {8'h00, a16}, 16'd0);
    peek(2'b01, a16, a8); check("sat16_hi", {8'h00, a16}, 16'h0002);
    sig_mode = 0; sig_level = 1'b0;
    wait_windows(2);
    peek(2'b00, a16, a8); peek(2'b10, b16, b8);
    check("idle8_res", {8'h00, a8}, 16'h0000);
    check("idle8_ovf", {15'd0, b8[6]}, 16'd0);

    // Hold across a window end while the rate changes.
    gsel = 2'd0; sig_mode = 1; sig_period = 4;
    wait_windows(3);
    hold = 1'b1; sig_period = 8;
    wait_windows(2);
    peek(2'b00, a16, a8); check("hold_keep", {8'h00, a16}, 16'd16);
    hold = 1'b0;
    wait_windows(1);
    peek(2'b00, a16, a8); check("hold_release", {8'h00, a16}, 16'd8);

    // gsel 0 -> 3 mid-window, then a reset pulse mid-window.
    wait_windows(1);
    run(20);
    gsel = 2'd3; sig_mode = 2;
    wait_windows(2);
    run(1000);
    rst_n = 1'b0;
    run(2);
    peek(2'b00, a16, a8); check("midrst_res", {a16, a8}, 16'h0000);
    rst_n = 1'b1; gsel = 2'd0; sig_mode = 1; sig_period = 6;
    wait_windows(2);

    // Randomized rounds.
    for (int k = 0; k < 6; k++) begin
      gsel = 2'($urandom_range(0, 1));
      sig_mode = int'($urandom_range(0, 2));
      sig_period = int'($urandom_range(2, 12));
      sig_level = 1'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      wait_windows(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
